// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Conditions NUM_KEYS raw, active-low, asynchronous push buttons into clean
// pressed-high levels plus single-cycle press/release events and a long-press
// hold flag. Each channel runs independently:
//   keys_ni -> 2-flop synchronizer -> debounce counter -> level/pulse regs
//                                                      -> hold counter
//
// Optional feature macro: KEY_AUTOREPEAT_EN
//   When defined, a held key (key_hold_o high) re-issues key_press_o once on
//   the cycle the hold flag rises and then every RPT_CYC cycles until release.
//   When undefined, no repeat logic exists and REPEAT_MS is not used.
//
// Ports
//   clk_i          sole clock
//   rst_ni         asynchronous active-low reset
//   keys_ni        raw buttons, active-low, asynchronous to clk_i
//   key_level_o    debounced state, 1 = pressed
//   key_press_o    one-cycle pulse per accepted press (and per repeat)
//   key_release_o  one-cycle pulse per accepted release
//   key_hold_o     high while pressed for at least HOLD_MS
// -----------------------------------------------------------------------------
module key_conditioner #(
   parameter int unsigned NUM_KEYS    = 4,
   parameter int unsigned CLK_FREQ    = 100_000,
   parameter int unsigned DEBOUNCE_MS = 10,
   parameter int unsigned HOLD_MS     = 500,
   parameter int unsigned REPEAT_MS   = 100
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NUM_KEYS-1:0] keys_ni,
   output logic [NUM_KEYS-1:0] key_level_o,
   output logic [NUM_KEYS-1:0] key_press_o,
   output logic [NUM_KEYS-1:0] key_release_o,
   output logic [NUM_KEYS-1:0] key_hold_o
);

   // Cycle counts are formed in 64 bits so large clocks times long
   // durations cannot overflow before the divide.
   localparam logic [63:0] DB_CYC_L   = 64'(CLK_FREQ) * 64'(DEBOUNCE_MS) / 64'd1000;
   localparam logic [63:0] HOLD_CYC_L = 64'(CLK_FREQ) * 64'(HOLD_MS) / 64'd1000;
   localparam int unsigned DB_CYC     = 32'(DB_CYC_L);
   localparam int unsigned HOLD_CYC   = 32'(HOLD_CYC_L);
   localparam int unsigned DB_W       = $clog2(DB_CYC + 1);
   localparam int unsigned HOLD_W     = $clog2(HOLD_CYC + 1);

`ifdef KEY_AUTOREPEAT_EN
   localparam logic [63:0] RPT_CYC_L  = 64'(CLK_FREQ) * 64'(REPEAT_MS) / 64'd1000;
   localparam int unsigned RPT_CYC    = 32'(RPT_CYC_L);
   localparam int unsigned RPT_W      = $clog2(RPT_CYC + 1);

   generate
      if (RPT_CYC_L < 64'd1) begin : g_bad_rpt
         $error("key_conditioner: RPT_CYC must be at least 1");
      end
   endgenerate
`endif

   generate
      if (DB_CYC_L < 64'd1) begin : g_bad_db
         $error("key_conditioner: DB_CYC must be at least 1");
      end
      if (HOLD_CYC_L < 64'd1) begin : g_bad_hold
         $error("key_conditioner: HOLD_CYC must be at least 1");
      end
   endgenerate

   // Synchronizer flops hold the raw active-low value; reset parks them at
   // "released" (1) so nothing looks pressed coming out of reset.
   logic [NUM_KEYS-1:0] sync1_q;
   logic [NUM_KEYS-1:0] sync2_q;
   logic [NUM_KEYS-1:0] sync_pressed;

   logic [NUM_KEYS-1:0] level_q,   level_d;
   logic [NUM_KEYS-1:0] press_q,   press_d;
   logic [NUM_KEYS-1:0] release_q, release_d;

   logic [DB_W-1:0]     db_cnt_q   [NUM_KEYS];
   logic [DB_W-1:0]     db_cnt_d   [NUM_KEYS];
   logic [HOLD_W-1:0]   hold_cnt_q [NUM_KEYS];
   logic [HOLD_W-1:0]   hold_cnt_d [NUM_KEYS];
`ifdef KEY_AUTOREPEAT_EN
   logic [RPT_W-1:0]    rpt_cnt_q  [NUM_KEYS];
   logic [RPT_W-1:0]    rpt_cnt_d  [NUM_KEYS];
`endif

   assign sync_pressed = ~sync2_q;

   always_comb begin
      level_d    = level_q;
      press_d    = '0;
      release_d  = '0;
      key_hold_o = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         db_cnt_d[k]   = '0;
         hold_cnt_d[k] = '0;
`ifdef KEY_AUTOREPEAT_EN
         rpt_cnt_d[k]  = '0;
`endif
         // Debounce: the counter only runs while the synchronized input
         // disagrees with the accepted level; the sample that would reach
         // DB_CYC flips the level instead of being stored.
         if (sync_pressed[k] != level_q[k]) begin
            if (db_cnt_q[k] == DB_W'(DB_CYC - 1)) begin
               level_d[k]   = ~level_q[k];
               press_d[k]   = ~level_q[k];
               release_d[k] = level_q[k];
            end else begin
               db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
            end
         end

         // Hold counter runs only while the key stays pressed this cycle and
         // the next; a release edge clears it together with the level.
         if (level_q[k] && level_d[k]) begin
            if (hold_cnt_q[k] == HOLD_W'(HOLD_CYC)) begin
               hold_cnt_d[k] = hold_cnt_q[k];
            end else begin
               hold_cnt_d[k] = hold_cnt_q[k] + HOLD_W'(1);
            end
`ifdef KEY_AUTOREPEAT_EN
            // First repeat lands on the cycle the hold flag rises; later
            // repeats are spaced RPT_CYC apart. Repeats are only issued while
            // no release edge is being taken, so press and release never
            // coincide.
            if (hold_cnt_q[k] == HOLD_W'(HOLD_CYC - 1)) begin
               press_d[k] = 1'b1;
            end else if (hold_cnt_q[k] == HOLD_W'(HOLD_CYC)) begin
               if (rpt_cnt_q[k] == RPT_W'(RPT_CYC - 1)) begin
                  press_d[k] = 1'b1;
               end else begin
                  rpt_cnt_d[k] = rpt_cnt_q[k] + RPT_W'(1);
               end
            end
`endif
         end

         key_hold_o[k] = level_q[k] && (hold_cnt_q[k] == HOLD_W'(HOLD_CYC));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int k = 0; k < NUM_KEYS; k++) begin
            db_cnt_q[k]   <= '0;
            hold_cnt_q[k] <= '0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt_q[k]  <= '0;
`endif
         end
      end else begin
         sync1_q   <= keys_ni;
         sync2_q   <= sync1_q;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int k = 0; k < NUM_KEYS; k++) begin
            db_cnt_q[k]   <= db_cnt_d[k];
            hold_cnt_q[k] <= hold_cnt_d[k];
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt_q[k]  <= rpt_cnt_d[k];
`endif
         end
      end
   end

   assign key_level_o   = level_q;
   assign key_press_o   = press_q;
   assign key_release_o = release_q;

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//
// Bench for key_conditioner with CLK_FREQ=1000, DEBOUNCE_MS=4, HOLD_MS=10,
// REPEAT_MS=5 (DB_CYC=4, HOLD_CYC=10, RPT_CYC=5). Every press/release pulse
// the DUT should emit is queued as {cycle, press, release} when the stimulus
// is driven; a negedge monitor pops and compares each pulse it observes.
// Inputs change 1 ns after a rising edge; cyc holds the number of rising
// edges seen so far, so a change driven at cyc=N is expected to reach the
// outputs at edge N+6.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

   localparam int NK = 4;
   localparam int W  = 32 + NK + NK;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [NK-1:0] keys  = '1;
   logic [NK-1:0] key_level_o;
   logic [NK-1:0] key_press_o;
   logic [NK-1:0] key_release_o;
   logic [NK-1:0] key_hold_o;

   int            cyc    = 0;
   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  exp_q[$];

   key_conditioner #(
      .NUM_KEYS    (NK),
      .CLK_FREQ    (1000),
      .DEBOUNCE_MS (4),
      .HOLD_MS     (10),
      .REPEAT_MS   (5)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .keys_ni       (keys),
      .key_level_o   (key_level_o),
      .key_press_o   (key_press_o),
      .key_release_o (key_release_o),
      .key_hold_o    (key_hold_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (key_press_o != '0 || key_release_o != '0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b, none expected",
                     cyc, key_press_o, key_release_o);
         end else begin
            e = exp_q.pop_front();
            if (cyc !== int'(e[W-1:2*NK]) || key_press_o !== e[2*NK-1:NK] ||
                key_release_o !== e[NK-1:0]) begin
               errors++;
               $display("FAIL pulse got cyc=%0d press=%b release=%b want cyc=%0d press=%b release=%b",
                        cyc, key_press_o, key_release_o, int'(e[W-1:2*NK]),
                        e[2*NK-1:NK], e[NK-1:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_evt(input int at, input logic [NK-1:0] p, input logic [NK-1:0] r);
      exp_q.push_back({32'(at), p, r});
   endtask

   // Waits (bounded) for the queue to empty, then idles so stray pulses show.
   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         step(1);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing got %0d pending events want 0", name, exp_q.size());
         exp_q.delete();
      end
      step(4);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      keys  = '1;
      step(3);
      checks++;
      if ({key_level_o, key_press_o, key_release_o, key_hold_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0",
                  {key_level_o, key_press_o, key_release_o, key_hold_o});
      end
      rst_n = 1'b1;
      step(10);
      checks++;
      if ({key_level_o, key_hold_o} !== '0) begin
         errors++;
         $display("FAIL idle_outputs got level=%b hold=%b want 0000 0000",
                  key_level_o, key_hold_o);
      end
   endtask

   task automatic test_clean_press();
      int t;
      t = cyc;
      keys[1] = 1'b0;
      expect_evt(t + 6, 4'b0010, 4'b0000);
      step(5);
      checks++;
      if (key_level_o !== 4'b0000) begin
         errors++;
         $display("FAIL press_early_level got %b want 0000", key_level_o);
      end
      step(1);
      checks++;
      if (key_level_o !== 4'b0010 || key_hold_o !== 4'b0000) begin
         errors++;
         $display("FAIL press_level got level=%b hold=%b want 0010 0000", key_level_o, key_hold_o);
      end
      step(2);
      keys[1] = 1'b1;
      expect_evt(cyc + 6, 4'b0000, 4'b0010);
      drain("clean_press");
      checks++;
      if (key_level_o !== 4'b0000) begin
         errors++;
         $display("FAIL release_level got %b want 0000", key_level_o);
      end
   endtask

   // Two 3-cycle glitches separated by one released sample: the count must
   // restart from zero, so neither may reach DB_CYC.
   task automatic test_glitch();
      keys[0] = 1'b0;
      step(3);
      keys[0] = 1'b1;
      step(1);
      keys[0] = 1'b0;
      step(3);
      keys[0] = 1'b1;
      step(12);
      checks++;
      if ({key_level_o, key_hold_o} !== '0) begin
         errors++;
         $display("FAIL glitch_level got level=%b hold=%b want 0000 0000", key_level_o, key_hold_o);
      end
      drain("glitch");
   endtask

   task automatic test_bounce();
      int t;
      keys[2] = 1'b0; step(1);
      keys[2] = 1'b1; step(1);
      keys[2] = 1'b0; step(1);
      keys[2] = 1'b1; step(1);
      keys[2] = 1'b0;
      t = cyc;
      expect_evt(t + 6, 4'b0100, 4'b0000);
      step(5);
      checks++;
      if (key_level_o !== 4'b0000) begin
         errors++;
         $display("FAIL bounce_early_level got %b want 0000", key_level_o);
      end
      step(1);
      checks++;
      if (key_level_o !== 4'b0100) begin
         errors++;
         $display("FAIL bounce_level got %b want 0100", key_level_o);
      end
      keys[2] = 1'b1;
      expect_evt(cyc + 6, 4'b0000, 4'b0100);
      drain("bounce");
   endtask

   task automatic test_hold();
      int t;
      t = cyc;
      keys[3] = 1'b0;
      expect_evt(t + 6, 4'b1000, 4'b0000);
`ifdef KEY_AUTOREPEAT_EN
      expect_evt(t + 16, 4'b1000, 4'b0000);
      expect_evt(t + 21, 4'b1000, 4'b0000);
      expect_evt(t + 26, 4'b1000, 4'b0000);
      expect_evt(t + 31, 4'b1000, 4'b0000);
`endif
      expect_evt(t + 32, 4'b0000, 4'b1000);
      step(15);
      checks++;
      if (key_hold_o !== 4'b0000 || key_level_o !== 4'b1000) begin
         errors++;
         $display("FAIL hold_early got hold=%b level=%b want 0000 1000", key_hold_o, key_level_o);
      end
      step(1);
      checks++;
      if (key_hold_o !== 4'b1000) begin
         errors++;
         $display("FAIL hold_assert got %b want 1000", key_hold_o);
      end
      step(10);
      keys[3] = 1'b1;
      step(5);
      checks++;
      if (key_hold_o !== 4'b1000 || key_level_o !== 4'b1000) begin
         errors++;
         $display("FAIL hold_before_release got hold=%b level=%b want 1000 1000",
                  key_hold_o, key_level_o);
      end
      step(1);
      checks++;
      if (key_hold_o !== 4'b0000 || key_level_o !== 4'b0000 || key_release_o !== 4'b1000) begin
         errors++;
         $display("FAIL hold_release got hold=%b level=%b release=%b want 0000 0000 1000",
                  key_hold_o, key_level_o, key_release_o);
      end
      drain("hold");
   endtask

   task automatic test_simultaneous_reset();
      int t;
      t = cyc;
      keys = 4'b0000;
      expect_evt(t + 6, 4'b1111, 4'b0000);
      step(6);
      checks++;
      if (key_level_o !== 4'b1111) begin
         errors++;
         $display("FAIL simul_level got %b want 1111", key_level_o);
      end
      step(1);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({key_level_o, key_press_o, key_release_o, key_hold_o} !== '0) begin
         errors++;
         $display("FAIL reset_async got %h want 0",
                  {key_level_o, key_press_o, key_release_o, key_hold_o});
      end
      step(2);
      checks++;
      if ({key_level_o, key_press_o, key_release_o, key_hold_o} !== '0) begin
         errors++;
         $display("FAIL reset_held got %h want 0",
                  {key_level_o, key_press_o, key_release_o, key_hold_o});
      end
      rst_n = 1'b1;
      t = cyc;
      expect_evt(t + 6, 4'b1111, 4'b0000);
      step(5);
      checks++;
      if (key_level_o !== 4'b0000) begin
         errors++;
         $display("FAIL post_reset_early got %b want 0000", key_level_o);
      end
      step(1);
      checks++;
      if (key_level_o !== 4'b1111) begin
         errors++;
         $display("FAIL post_reset_level got %b want 1111", key_level_o);
      end
      step(2);
      keys = 4'b1111;
      expect_evt(cyc + 6, 4'b0000, 4'b1111);
      drain("simul_reset");
   endtask

   task automatic test_back_to_back();
      int t;
      t = cyc;
      keys[0] = 1'b0;
      expect_evt(t + 6, 4'b0001, 4'b0000);
      step(1);
      keys[1] = 1'b0;
      expect_evt(t + 7, 4'b0010, 4'b0000);
      step(6);
      checks++;
      if (key_level_o !== 4'b0011) begin
         errors++;
         $display("FAIL b2b_level got %b want 0011", key_level_o);
      end
      step(1);
      keys = 4'b1111;
      expect_evt(cyc + 6, 4'b0000, 4'b0011);
      drain("back_to_back");
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_bounce();
      test_hold();
      test_simultaneous_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_KEYS, 4, number of independent push-button channels.
- CLK_FREQ, 100_000, clk_i frequency in Hz.
- DEBOUNCE_MS, 10, required stable time before a level change is accepted.
- HOLD_MS, 500, press duration before key_hold_o asserts.
- REPEAT_MS, 100, auto-repeat period (used only with KEY_AUTOREPEAT_EN).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, input, 1, sole clock; game clock domain.
- rst_ni, input, 1, reset; asynchronous, active-low.
- keys_ni, input, NUM_KEYS, raw board buttons; active-low; asynchronous to clk_i.
- key_level_o, output, NUM_KEYS, debounced state; 1 = pressed.
- key_press_o, output, NUM_KEYS, one-cycle pulse on each accepted press (and on each repeat).
- key_release_o, output, NUM_KEYS, one-cycle pulse on each accepted release.
- key_hold_o, output, NUM_KEYS, high while the key has been pressed for at least HOLD_MS.

Function
REQ-003 Derived constants SHALL be DB_CYC = CLK_FREQ*DEBOUNCE_MS/1000, HOLD_CYC = CLK_FREQ*HOLD_MS/1000 and RPT_CYC = CLK_FREQ*REPEAT_MS/1000, computed with 64-bit integer arithmetic to avoid overflow; each SHALL be >= 1, otherwise elaboration fails.
REQ-004 Each keys_ni bit SHALL pass through a 2-flop synchronizer; logic downstream of the synchronizer SHALL see only the inverted second stage (sync = pressed-high).
REQ-005 Each channel SHALL have a debounce counter of width $clog2(DB_CYC+1). The counter SHALL clear on any cycle where sync equals key_level_o, and SHALL increment on any cycle where they differ.
REQ-006 On the edge where a differing sample would bring the counter to DB_CYC, key_level_o SHALL toggle and the counter SHALL clear. A glitch shorter than DB_CYC cycles SHALL therefore never change key_level_o.
REQ-007 End-to-end latency from a clean keys_ni transition to the key_level_o change SHALL be exactly DB_CYC+2 clk_i cycles.
REQ-008 key_press_o[k] (0->1) and key_release_o[k] (1->0) SHALL be registered and asserted in the same cycle key_level_o[k] changes, for exactly one cycle.
REQ-009 Each channel SHALL have a hold counter of width $clog2(HOLD_CYC+1). It SHALL clear while key_level_o[k]=0, increment while the key is pressed, and saturate at HOLD_CYC.
REQ-010 key_hold_o[k] SHALL be 1 when the hold counter equals HOLD_CYC and key_level_o[k]=1.
REQ-011 Release SHALL clear key_hold_o in the same cycle that key_release_o pulses.
REQ-012 Channels SHALL be fully independent: simultaneous events on several keys SHALL produce simultaneous per-bit pulses, and no event SHALL be dropped or serialized.
REQ-013 key_press_o and key_release_o SHALL never be high for the same bit in the same cycle.

Reset
REQ-014 While rst_ni=0, asynchronously: synchronizer flops = released, all counters = 0, and all outputs = 0.
REQ-015 A key held through reset deassertion SHALL be treated as a new press: key_press_o SHALL pulse DB_CYC+2 cycles after rst_ni rises.
REQ-016 Reset asserted mid-debounce or mid-hold SHALL discard the partial count, with no pulse on either edge of reset.

Configuration
REQ-017 Auto-repeat SHALL be controlled by macro KEY_AUTOREPEAT_EN.
- Defined: each channel SHALL have a repeat counter of width $clog2(RPT_CYC+1). Starting on the cycle key_hold_o[k] first asserts, key_press_o[k] SHALL pulse once immediately and then every RPT_CYC cycles while the key is held. Release SHALL stop repeats with no trailing pulse.
- Undefined: no repeat counter SHALL be instantiated, key_press_o SHALL pulse only per REQ-008, and REPEAT_MS SHALL be ignored.

Verification (CLK_FREQ=1000, DEBOUNCE_MS=4, HOLD_MS=10, REPEAT_MS=5 -> DB_CYC=4, HOLD_CYC=10, RPT_CYC=5)
REQ-018 Clean press: keys_ni[1] goes 1->0 at cycle 0 -> key_level_o[1]=1 and key_press_o[1] pulses at cycle 6; all other bits stay 0.
REQ-019 Glitch: keys_ni[0] low for 3 cycles, then high -> no change on any output; the debounce counter returns to 0.
REQ-020 Bounce: keys_ni[2] toggles low/high/low/high/low at 1-cycle spacing, then stays low -> exactly one key_press_o[2] pulse, 6 cycles after the final falling edge.
REQ-021 Hold and release: keys_ni[3] held low for 20 cycles after key_level_o rises -> key_hold_o[3]=1 from 10 cycles after the press pulse. Release -> key_release_o[3] pulses and key_hold_o[3] drops in the same cycle.
REQ-022 Simultaneous keys plus reset: keys_ni=4'b0000 at cycle 0 -> key_press_o=4'b1111 at cycle 6. Then rst_ni=0 for 2 cycles while keys stay low -> all outputs 0 during reset, and key_press_o=4'b1111 again 6 cycles after rst_ni rises.
REQ-023 With KEY_AUTOREPEAT_EN defined and keys_ni[0] held -> key_press_o[0] pulses at press, at hold+0, then every 5 cycles. Without the macro -> a single pulse only.
